example_split: RTL
==================

Name: example_split

Overview:
- AXI4-Stream splitter: the inverse of the existing dual-input combiner block.
- Accepts one wide input beat and splits it into two half-width beats.
  - Low half goes out on stream A; high half goes out on stream B.
- Each output has its own small FIFO, so A and B drain independently under separate backpressure.
- Sits upstream of the combiner in loopback benches, and anywhere a packed stream must be fanned out to two consumers.

Parameters:
- TDATA_WIDTH_BYTES, 4, byte width of each output stream; input is 2*TDATA_WIDTH_BYTES bytes.
- FIFO_DEPTH, 2, entries per output FIFO; power of two, minimum 2.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted when high with tvalid.
- s_axis_tdata  input  16*TDATA_WIDTH_BYTES  packed input: [8*TDATA_WIDTH_BYTES-1:0]=A, upper half=B.
- m_axis_a_tvalid  output  1  stream A valid.
- m_axis_a_tready  input  1  stream A ready.
- m_axis_a_tdata  output  8*TDATA_WIDTH_BYTES  stream A data.
- m_axis_b_tvalid  output  1  stream B valid.
- m_axis_b_tready  input  1  stream B ready.
- m_axis_b_tdata  output  8*TDATA_WIDTH_BYTES  stream B data.

Behaviour:
- Clocking and reset: one clock, aclk. Reset is asynchronous and active-low on resetn.
- Reset values:
  - FIFO pointers and counts are 0.
  - m_axis_a_tvalid and m_axis_b_tvalid are 0.
  - tdata outputs are don't-care; the bench must not check them.
  - s_axis_tready is 0 while resetn=0.
- Input handshake:
  - s_axis_tready = resetn_sync_state && !full_a && !full_b.
  - s_axis_tready depends only on registered state; there is no combinational path from m_*_tready.
  - Push occurs when s_axis_tvalid && s_axis_tready. Both FIFOs are written in the same cycle. A beat is never split across cycles.
- Output handshake:
  - m_axis_x_tvalid = !empty_x.
  - m_axis_x_tdata = head entry of FIFO x.
  - Pop occurs on m_axis_x_tvalid && m_axis_x_tready.
  - Once asserted, tvalid and tdata stay stable until popped (AXIS rule).
- Latency:
  - A beat accepted at edge N is visible on both outputs after edge N, i.e. valid in the cycle following acceptance.
  - There is no combinational bypass from input to output.
- Throughput: with both readies high, 1 beat/cycle is sustained.
- Simultaneous push and pop on the same FIFO:
  - Count is unchanged; the head advances.
  - This is legal whenever the FIFO is not full at the start of the cycle.
- Full condition:
  - If either FIFO reaches FIFO_DEPTH, s_axis_tready drops the next cycle.
  - The other FIFO continues draining.
- Empty condition: tvalid stays low. Pop is impossible.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-operation:
  - All stored beats are discarded and both valids drop immediately (asynchronous).
  - After deassertion, s_axis_tready rises on the first edge.
- Ordering: the order within each stream equals the input order. A and B beats with the same index came from the same input beat.

Optional Feature:
- Macro: EXAMPLE_SPLIT_STATS_EN
- When defined, the block adds these output ports:
  - beat_count (32-bit): increments per accepted input beat and wraps at 2^32.
  - stall_count (32-bit): increments per cycle with s_axis_tvalid && !s_axis_tready while resetn=1 and saturates at 0xFFFF_FFFF.
- Both counters reset to 0.
- When not defined, the ports and logic are absent, and datapath behaviour is identical.

Decomposition:
- Package example_split_pkg holds:
  - localparam function for data width (8*bytes).
  - clog2 helper.
  - typedef for the FIFO count type.
- Natural sub-module: example_split_fifo. It is a synchronous FIFO, parameterised width/depth, with push/pop/full/empty/head, asynchronous active-low reset. It is instantiated twice.
- The top level holds the handshake glue and the optional stats.

Test Plan:
1. Reset: hold resetn=0 for 5 cycles with s_axis_tvalid=1 -> s_axis_tready=0, both m tvalid=0; release -> s_axis_tready=1 on first edge.
2. Single beat: s_axis_tdata=0xDEADBEEF_12345678, readies high -> next cycle A=0x12345678 and B=0xDEADBEEF both valid; both popped within 1 cycle.
3. Streaming: 100 incrementing beats (A=i, B=i+0x1000), both readies high -> 1 beat/cycle, no stalls, order preserved.
4. Asymmetric backpressure: hold m_axis_b_tready=0 and send 4 beats -> tready drops after 2 accepted (FIFO_DEPTH=2). A drains 2 beats. Raise B ready -> remaining 2 beats accepted; all 4 appear on both streams in order.
5. Reset mid-stream: assert resetn=0 with 1 entry in each FIFO -> valids drop asynchronously; after release, both FIFOs are empty and a fresh beat 0x1/0x2 emerges correctly.
6. EXAMPLE_SPLIT_STATS_EN: run scenario 4 -> beat_count=4 and stall_count equals the number of cycles with tvalid high and tready low (compare against bench model).

Source files
------------

// File: rtl/example_split_pkg.sv
// Shared types and width helpers for the example_split AXI4-Stream splitter.
package example_split_pkg;

  localparam int unsigned TDATA_WIDTH_BYTES_DFLT = 4;
  localparam int unsigned FIFO_DEPTH_DFLT        = 2;

  // Ceiling log2, constant-evaluable for parameter derivation.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned data_width(input int unsigned bytes);
    return 8 * bytes;
  endfunction

  localparam int unsigned FIFO_CNT_W = clog2(FIFO_DEPTH_DFLT) + 1;
  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

endpackage

// File: rtl/example_split_if.sv
// Stream bundle for example_split: one wide input stream and two half-width outputs.
interface example_split_if #(
  parameter int unsigned TDATA_WIDTH_BYTES = example_split_pkg::TDATA_WIDTH_BYTES_DFLT
);
  import example_split_pkg::*;

  localparam int unsigned DW = data_width(TDATA_WIDTH_BYTES);

  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [2*DW-1:0] s_axis_tdata;
  logic            m_axis_a_tvalid;
  logic            m_axis_a_tready;
  logic [DW-1:0]   m_axis_a_tdata;
  logic            m_axis_b_tvalid;
  logic            m_axis_b_tready;
  logic [DW-1:0]   m_axis_b_tdata;

  // Splitter side of the bundle.
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_a_tready, m_axis_b_tready,
    output s_axis_tready, m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid, m_axis_b_tdata
  );

  // Environment side: drives the input stream and consumes both outputs.
  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_a_tready, m_axis_b_tready,
    input  s_axis_tready, m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid, m_axis_b_tdata
  );

endinterface

// File: rtl/example_split_fifo.sv
// Synchronous FIFO with registered full/empty flags; head is the oldest entry.
module example_split_fifo
  import example_split_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = FIFO_DEPTH_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; contents are only observed behind empty_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/example_split.sv
// AXI4-Stream splitter: low half of each input beat to stream A, high half to stream B.
// Define EXAMPLE_SPLIT_STATS_EN to add beat_count/stall_count ports.
module example_split
  import example_split_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH_BYTES = TDATA_WIDTH_BYTES_DFLT,
  parameter int unsigned FIFO_DEPTH        = FIFO_DEPTH_DFLT
) (
  input  logic            aclk,
  input  logic            resetn,
  example_split_if.slave  bus
`ifdef EXAMPLE_SPLIT_STATS_EN
  ,
  output logic [31:0]     beat_count,
  output logic [31:0]     stall_count
`endif
);

  localparam int unsigned DW = data_width(TDATA_WIDTH_BYTES);

  logic ready_en_q;
  logic full_a, full_b, empty_a, empty_b;
  logic s_ready, push;

  // Holds tready low during reset and releases it on the first edge afterwards.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) ready_en_q <= 1'b0;
    else         ready_en_q <= 1'b1;
  end

  assign s_ready           = ready_en_q && !full_a && !full_b;
  assign push              = bus.s_axis_tvalid && s_ready;
  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_a_tvalid = !empty_a;
  assign bus.m_axis_b_tvalid = !empty_b;

  example_split_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk     (aclk),
    .rst_n   (resetn),
    .push_i  (push),
    .data_i  (bus.s_axis_tdata[DW-1:0]),
    .pop_i   (bus.m_axis_a_tready),
    .full_o  (full_a),
    .empty_o (empty_a),
    .head_o  (bus.m_axis_a_tdata)
  );

  example_split_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk     (aclk),
    .rst_n   (resetn),
    .push_i  (push),
    .data_i  (bus.s_axis_tdata[2*DW-1:DW]),
    .pop_i   (bus.m_axis_b_tready),
    .full_o  (full_b),
    .empty_o (empty_b),
    .head_o  (bus.m_axis_b_tdata)
  );

`ifdef EXAMPLE_SPLIT_STATS_EN
  logic [31:0] beat_count_q, beat_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Beat count wraps; stall count saturates.
  always_comb begin
    beat_count_d  = beat_count_q;
    stall_count_d = stall_count_q;
    if (push) beat_count_d = beat_count_q + 32'd1;
    if (bus.s_axis_tvalid && !s_ready && (stall_count_q != '1))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      beat_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      beat_count_q  <= beat_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign beat_count  = beat_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
